// File: rtl/safety_input_conditioner.sv
// Handlebar switch conditioner: per-channel synchroniser and debouncer, then shaping into
// a headlight toggle, a mutually exclusive blinker selector, and momentary horn/brake levels.
module safety_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       leftBtn,
  input  logic       rightBtn,
  input  logic       headBtn,
  input  logic       hornBtn,
  input  logic       brakeSw,
  output logic       leftBlinker,
  output logic       rightBlinker,
  output logic       headLight,
  output logic       horn,
  output logic       brakes,
  output logic [3:0] pressEvt,
  output logic [1:0] blink_state
);

  localparam int NCH = 5;
  // Channel order {brake, horn, head, right, left}; brake idles high (0 = applied).
  localparam logic [NCH-1:0] RST_LVL = 5'b10000;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } blink_t;

  logic [NCH-1:0]         raw;
  logic [SYNC_STAGES-1:0] sync_q [NCH];
  logic [CNT_W-1:0]       cnt    [NCH];
  logic [NCH-1:0]         stable;
  logic [3:0]             stable_d;
  logic [3:0]             rise;
  logic [3:0]             evt_q;
  logic                   head_q;
  blink_t                 state_q;
  blink_t                 state_d;

  assign raw = {brakeSw, hornBtn, headBtn, rightBtn, leftBtn};

  always_ff @(posedge CLOCK_50) begin
    for (int i = 0; i < NCH; i++) begin
      if (!reset_n) begin
        sync_q[i] <= {SYNC_STAGES{RST_LVL[i]}};
        stable[i] <= RST_LVL[i];
        cnt[i]    <= '0;
      end else begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
        // Any sample agreeing with the accepted level restarts the qualification window.
        if (sync_q[i][SYNC_STAGES-1] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          stable[i] <= sync_q[i][SYNC_STAGES-1];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign rise = stable[3:0] & ~stable_d;

  // Press strobes and the headlight toggle update on the same edge.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      stable_d <= '0;
      evt_q    <= '0;
      head_q   <= 1'b0;
    end else begin
      stable_d <= stable[3:0];
      evt_q    <= rise;
      head_q   <= head_q ^ rise[2];
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) state_q <= OFF;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    // Simultaneous left and right presses are ambiguous and leave the selection alone.
    if (!(evt_q[0] && evt_q[1])) begin
      case (state_q)
        OFF: begin
          if (evt_q[0])      state_d = LEFT;
          else if (evt_q[1]) state_d = RIGHT;
        end
        LEFT: begin
          if (evt_q[0])      state_d = OFF;
          else if (evt_q[1]) state_d = RIGHT;
        end
        RIGHT: begin
          if (evt_q[1])      state_d = OFF;
          else if (evt_q[0]) state_d = LEFT;
        end
        default: state_d = OFF;
      endcase
    end
  end

  assign leftBlinker  = (state_q == LEFT);
  assign rightBlinker = (state_q == RIGHT);
  assign headLight    = head_q;
  assign horn         = stable[3];
  assign brakes       = stable[4];
  assign pressEvt     = evt_q;
  assign blink_state  = state_q;

endmodule

// File: tb/tb_safety_input_conditioner.sv
// Directed bench for safety_input_conditioner with an 8-cycle debounce window:
// raw edge to stable level takes 10 edges, press strobe 11, blinker state 12.
module tb_safety_input_conditioner;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       left_btn, right_btn, head_btn, horn_btn, brake_sw;
  logic       left_blinker, right_blinker, head_light, horn, brakes;
  logic [3:0] press_evt;
  logic [1:0] blink_state;

  int vectors = 0;
  int errors  = 0;
  int bad;

  always #5 clk = ~clk;

  safety_input_conditioner #(
    .DEBOUNCE_CYCLES(8),
    .CNT_W          (3),
    .SYNC_STAGES    (2)
  ) dut (
    .CLOCK_50    (clk),
    .reset_n     (reset_n),
    .leftBtn     (left_btn),
    .rightBtn    (right_btn),
    .headBtn     (head_btn),
    .hornBtn     (horn_btn),
    .brakeSw     (brake_sw),
    .leftBlinker (left_blinker),
    .rightBlinker(right_blinker),
    .headLight   (head_light),
    .horn        (horn),
    .brakes      (brakes),
    .pressEvt    (press_evt),
    .blink_state (blink_state)
  );

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    left_btn  = 1'b0;
    right_btn = 1'b0;
    head_btn  = 1'b0;
    horn_btn  = 1'b0;
    brake_sw  = 1'b1;
    step(3);

    // 1: reset with every input active
    left_btn = 1'b1; right_btn = 1'b1; head_btn = 1'b1; horn_btn = 1'b1; brake_sw = 1'b0;
    step(2);
    chk("rst_outputs", {left_blinker, right_blinker, head_light, horn}, 4'b0000);
    chk("rst_brakes", {3'b000, brakes}, 4'b0001);
    chk("rst_evt", press_evt, 4'b0000);
    reset_n = 1'b1;
    step(9);
    chk("brake_before_10", {3'b000, brakes}, 4'b0001);
    step(1);
    chk("brake_at_10", {3'b000, brakes}, 4'b0000);
    chk("horn_at_10", {3'b000, horn}, 4'b0001);
    chk("evt_at_10", press_evt, 4'b0000);
    step(1);
    chk("evt_all_at_11", press_evt, 4'b1111);
    chk("head_at_11", {3'b000, head_light}, 4'b0001);
    step(1);
    chk("evt_all_gone", press_evt, 4'b0000);
    chk("blink_ambig_rst", {2'b00, blink_state}, 4'b0000);
    left_btn = 1'b0; right_btn = 1'b0; head_btn = 1'b0; horn_btn = 1'b0; brake_sw = 1'b1;
    step(15);
    chk("brake_released", {3'b000, brakes}, 4'b0001);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    chk("head_cleared", {3'b000, head_light}, 4'b0000);

    // 2: headlight toggle
    head_btn = 1'b1;
    step(10);
    chk("head_evt_early", press_evt, 4'b0000);
    step(1);
    chk("head_evt", press_evt, 4'b0100);
    chk("head_on", {3'b000, head_light}, 4'b0001);
    step(1);
    chk("head_evt_once", press_evt, 4'b0000);
    step(8);
    head_btn = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (press_evt != 4'b0000) bad++;
    end
    chk("head_release_no_evt", bad[3:0], 4'd0);
    chk("head_still_on", {3'b000, head_light}, 4'b0001);
    head_btn = 1'b1;
    step(11);
    chk("head_evt2", press_evt, 4'b0100);
    chk("head_off", {3'b000, head_light}, 4'b0000);
    step(9);
    head_btn = 1'b0;
    step(12);

    // 3: horn glitch rejection, then a real hold
    horn_btn = 1'b1; step(5);
    horn_btn = 1'b0; step(3);
    horn_btn = 1'b1; step(5);
    horn_btn = 1'b0;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (horn || press_evt[3]) bad++;
    end
    chk("horn_glitch", bad[3:0], 4'd0);
    horn_btn = 1'b1;
    step(9);
    chk("horn_before_10", {3'b000, horn}, 4'b0000);
    step(1);
    chk("horn_on", {3'b000, horn}, 4'b0001);
    step(1);
    chk("horn_evt", press_evt, 4'b1000);
    step(1);
    horn_btn = 1'b0;
    step(9);
    chk("horn_hold_after_rel", {3'b000, horn}, 4'b0001);
    step(1);
    chk("horn_off", {3'b000, horn}, 4'b0000);
    chk("horn_rel_no_evt", press_evt, 4'b0000);
    step(4);

    // 4: blinker selector
    left_btn = 1'b1;
    step(11);
    chk("left_evt", press_evt, 4'b0001);
    chk("left_not_yet", {2'b00, left_blinker, right_blinker}, 4'b0000);
    step(1);
    chk("left_sel", {2'b00, left_blinker, right_blinker}, 4'b0010);
    chk("left_state", {2'b00, blink_state}, 4'b0001);
    left_btn = 1'b0;
    step(12);
    right_btn = 1'b1;
    step(12);
    chk("right_sel", {2'b00, left_blinker, right_blinker}, 4'b0001);
    chk("right_state", {2'b00, blink_state}, 4'b0010);
    right_btn = 1'b0;
    step(12);
    right_btn = 1'b1;
    step(12);
    chk("right_off", {2'b00, left_blinker, right_blinker}, 4'b0000);
    right_btn = 1'b0;
    step(12);

    // 5: simultaneous presses are ignored
    left_btn = 1'b1; right_btn = 1'b1;
    step(11);
    chk("both_evt", press_evt, 4'b0011);
    step(1);
    chk("both_from_off", {2'b00, left_blinker, right_blinker}, 4'b0000);
    left_btn = 1'b0; right_btn = 1'b0;
    step(12);
    left_btn = 1'b1;
    step(12);
    chk("left_again", {2'b00, left_blinker, right_blinker}, 4'b0010);
    left_btn = 1'b0;
    step(12);
    left_btn = 1'b1; right_btn = 1'b1;
    step(12);
    chk("both_from_left", {2'b00, left_blinker, right_blinker}, 4'b0010);
    left_btn = 1'b0; right_btn = 1'b0;
    step(12);

    // 6: reset in the middle of a head debounce
    head_btn = 1'b1;
    step(12);
    chk("head_on_pre6", {3'b000, head_light}, 4'b0001);
    head_btn = 1'b0;
    step(12);
    head_btn = 1'b1;
    step(5);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    chk("midrst_head", {3'b000, head_light}, 4'b0000);
    chk("midrst_blink", {2'b00, left_blinker, right_blinker}, 4'b0000);
    step(10);
    chk("midrst_no_early_evt", press_evt, 4'b0000);
    chk("midrst_head_wait", {3'b000, head_light}, 4'b0000);
    step(1);
    chk("midrst_evt", press_evt, 4'b0100);
    chk("midrst_head_on", {3'b000, head_light}, 4'b0001);
    head_btn = 1'b0;
    step(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
